mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access (M) stage of the 5-stage RISC-V pipeline; consumes the EX/MEM register outputs produced by the execute stage.
- Drives a request/ready data-memory bus and performs byte/half/word load-store alignment and load extension.
- Resolves the branch decision and stalls the upstream pipeline on memory wait states.
- Registers results into the MEM/WB register, which feeds writeback and the execute-stage forwarding muxes.

Parameters:
- TIMEOUT, 255: maximum wait-state cycles before a bus error is declared (1..255).
- XLEN, 32: data/address width. Only 32 is supported.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- memToRegM, regWriteM, memReadM, memWriteM, branchM, alu_zeroM  in  1 each  EX/MEM control bits.
- func3M  in  3  load/store size code.
- write_regM  in  5  destination register.
- alu_outM  in  32  ALU result, used as the effective address.
- write_dataM  in  32  store data.
- PC_M  in  32  branch target computed in EX.
- pcSrcM  out  1  branch taken, combinational: branchM & alu_zeroM.
- branch_targetM  out  32  equals PC_M.
- stallM  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- dmem_req  out  1  bus request.
- dmem_we  out  1  write enable.
- dmem_addr  out  32  word address: {alu_outM[31:2],2'b00}.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ready  in  1  access complete.
- dmem_rdata  in  32  read word.
- memToRegW, regWriteW  out  1 each  MEM/WB control bits.
- write_regW  out  5  MEM/WB destination register.
- dataReadW  out  32  extended load data.
- alu_outW  out  32  MEM/WB ALU result.
- misalign_err, bus_err  out  1 each  registered one-cycle error pulses.

Behaviour:
- Reset (reset=0, asynchronous): all registered outputs are 0, FSM is IDLE, wait counter is 0. Bus request outputs are 0 while reset is low.
- memop = memReadM | memWriteM.
- Alignment:
  - aligned when func3M[1:0]=00 (byte), or 01 with addr[0]=0 (half), or 10 with addr[1:0]=0 (word).
  - func3M[1:0]=11 is treated as misaligned.
- FSM states: IDLE and WAIT.
  - dmem_req = (IDLE & memop & aligned) | WAIT. The request is combinational, so a zero-wait access completes in the same cycle.
  - IDLE -> WAIT when dmem_req & ~dmem_ready.
  - WAIT -> IDLE on dmem_ready.
  - WAIT -> IDLE on a timeout (counter reaches TIMEOUT-1 without ready). Pulse bus_err and write a bubble into MEM/WB.
  - The counter clears on entering WAIT.
- stallM = dmem_req & ~dmem_ready & ~timeout. EX/MEM inputs are held stable by upstream while stallM=1.
- Store lanes:
  - SB: be = 0001<<addr[1:0], wdata = byte replicated x4.
  - SH: be = 0011<<{addr[1],1'b0}, wdata = half replicated x2.
  - SW: be = 1111.
  - Loads drive be=1111 and we=0.
- Load extract:
  - Select byte by addr[1:0], half by addr[1].
  - func3M 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend.
- Misaligned memop: no request is issued, misalign_err pulses next cycle, MEM/WB receives a bubble (regWriteW=0, memToRegW=0).
- MEM/WB update, every rising edge:
  - stallM=1, misaligned, or timeout: regWriteW=0, memToRegW=0, other W fields hold.
  - Otherwise: copy control, write_regW and alu_outW; dataReadW takes the extended rdata on a load completion, else holds.
- Branch outputs are purely combinational and ignore stalls. Flush is handled by the hazard unit.
- Reset asserted mid-WAIT: dmem_req drops immediately and no completion is recorded. The bus slave must abort on req deassertion.

Decomposition:
- Shared package (rv_pkg):
  - func3 load/store codes: LB, LH, LW, LBU, LHU, SB, SH, SW.
  - FSM state encoding: IDLE=0, WAIT=1.
  - XLEN.
- One sub-module, load_store_align: combinational lane and be generation, load extension, and the aligned flag. This keeps the FSM and pipeline register in the top level.

Test Plan:
- LW addr 0x100, dmem_ready held 1, rdata 0xDEADBEEF, regWriteM=1, memToRegM=1, rd=5 -> req in the same cycle, stallM=0, next edge dataReadW=0xDEADBEEF, write_regW=5.
- LB addr 0x103, rdata 0x80123456 -> dataReadW=0xFFFFFF80. Repeat as LBU -> 0x00000080.
- SH addr 0x102, write_dataM=0x0000ABCD -> dmem_be=1100, dmem_wdata=0xABCDABCD, dmem_we=1, dmem_addr=0x100.
- LW with ready delayed 3 cycles -> stallM=1 for 3 cycles with a bubble in MEM/WB each of those cycles, WB updated on the 4th edge, bus inputs stable throughout.
- LW addr 0x102 -> no dmem_req, misalign_err pulse, regWriteW=0. Separately, TIMEOUT=4 with ready never asserted -> bus_err pulse after 4 cycles, stallM drops, FSM returns to IDLE.
- reset driven low while in WAIT -> dmem_req=0 and all W outputs 0 immediately. After release, the next LW completes normally.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RV32 definitions for the memory-access stage: load/store size codes,
// the bus FSM state encoding and the datapath width.
package rv_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } mem_state_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational store lane/byte-enable generation, load extraction/extension and alignment check.
// Zero latency, no state; backpressure is handled entirely by the caller.
module load_store_align
   import rv_pkg::*;
(
   input  logic [2:0]  func3,
   input  logic [1:0]  addr,
   input  logic        is_store,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic        aligned,
   output logic [3:0]  be,
   output logic [31:0] lane_wdata,
   output logic [31:0] load_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      aligned = 1'b0;
      case (func3[1:0])
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~addr[0];
         2'b10:   aligned = (addr == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   // Loads always fetch the whole word; only stores narrow the enables.
   always_comb begin
      be         = 4'b1111;
      lane_wdata = wdata;
      if (is_store) begin
         case (func3[1:0])
            2'b00: begin
               be         = 4'b0001 << addr;
               lane_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
               be         = 4'b0011 << {addr[1], 1'b0};
               lane_wdata = {2{wdata[15:0]}};
            end
            default: begin
               be         = 4'b1111;
               lane_wdata = wdata;
            end
         endcase
      end
   end

   always_comb begin
      byte_sel  = rdata[{addr, 3'b000} +: 8];
      half_sel  = addr[1] ? rdata[31:16] : rdata[15:0];
      load_data = rdata;
      case (func3)
         F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
         F3_LW:   load_data = rdata;
         F3_LBU:  load_data = {24'h000000, byte_sel};
         F3_LHU:  load_data = {16'h0000, half_sel};
         default: load_data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// RISC-V M stage: data-memory bus FSM, MEM/WB register and branch resolution; zero-wait
// accesses complete in-cycle, otherwise stallM freezes upstream until ready or timeout.
module mem_access_stage
   import rv_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int XLEN    = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            memToRegM,
   input  logic            regWriteM,
   input  logic            memReadM,
   input  logic            memWriteM,
   input  logic            branchM,
   input  logic            alu_zeroM,
   input  logic [2:0]      func3M,
   input  logic [4:0]      write_regM,
   input  logic [XLEN-1:0] alu_outM,
   input  logic [XLEN-1:0] write_dataM,
   input  logic [XLEN-1:0] PC_M,
   output logic            pcSrcM,
   output logic [XLEN-1:0] branch_targetM,
   output logic            stallM,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [3:0]      dmem_be,
   input  logic            dmem_ready,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            memToRegW,
   output logic            regWriteW,
   output logic [4:0]      write_regW,
   output logic [XLEN-1:0] dataReadW,
   output logic [XLEN-1:0] alu_outW,
   output logic            misalign_err,
   output logic            bus_err
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   mem_state_t  state, state_nxt;
   logic [7:0]  wait_cnt;
   logic        memop, aligned, req_raw, timeout, misalign, complete;
   logic [3:0]  be;
   logic [31:0] lane_wdata, load_data;

   load_store_align u_align (
      .func3      (func3M),
      .addr       (alu_outM[1:0]),
      .is_store   (memWriteM),
      .wdata      (write_dataM),
      .rdata      (dmem_rdata),
      .aligned    (aligned),
      .be         (be),
      .lane_wdata (lane_wdata),
      .load_data  (load_data)
   );

   assign memop    = memReadM | memWriteM;
   assign misalign = (state == IDLE) & memop & ~aligned;

   always_comb begin
      state_nxt = state;
      req_raw   = 1'b0;
      timeout   = 1'b0;
      case (state)
         IDLE: begin
            req_raw = memop & aligned;
            if (req_raw & ~dmem_ready)
               state_nxt = WAIT;
         end
         WAIT: begin
            req_raw = 1'b1;
            if (dmem_ready)
               state_nxt = IDLE;
            else if (wait_cnt == TMO_LAST) begin
               timeout   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request is qualified by reset so an in-flight access is dropped the instant reset asserts.
   assign dmem_req   = req_raw & reset;
   assign dmem_we    = dmem_req & memWriteM;
   assign dmem_be    = reset ? be : 4'b0000;
   assign dmem_addr  = {alu_outM[31:2], 2'b00};
   assign dmem_wdata = lane_wdata;
   assign complete   = dmem_req & dmem_ready;
   assign stallM     = dmem_req & ~dmem_ready & ~timeout;

   assign pcSrcM         = branchM & alu_zeroM;
   assign branch_targetM = PC_M;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         wait_cnt <= 8'd0;
      end else begin
         state <= state_nxt;
         if (state == IDLE)
            wait_cnt <= 8'd0;
         else
            wait_cnt <= wait_cnt + 8'd1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         memToRegW    <= 1'b0;
         regWriteW    <= 1'b0;
         write_regW   <= 5'd0;
         dataReadW    <= '0;
         alu_outW     <= '0;
         misalign_err <= 1'b0;
         bus_err      <= 1'b0;
      end else begin
         misalign_err <= misalign;
         bus_err      <= timeout;
         if (stallM | misalign | timeout) begin
            regWriteW <= 1'b0;
            memToRegW <= 1'b0;
         end else begin
            regWriteW  <= regWriteM;
            memToRegW  <= memToRegM;
            write_regW <= write_regM;
            alu_outW   <= alu_outM;
            if (memReadM & complete)
               dataReadW <= load_data;
         end
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against a transaction-level reference model.
module tb_mem_access_stage;

   localparam int TMO = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        memToRegM, regWriteM, memReadM, memWriteM, branchM, alu_zeroM;
   logic [2:0]  func3M;
   logic [4:0]  write_regM;
   logic [31:0] alu_outM, write_dataM, PC_M;
   logic        pcSrcM, stallM, dmem_req, dmem_we, dmem_ready;
   logic [31:0] branch_targetM, dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        memToRegW, regWriteW, misalign_err, bus_err;
   logic [4:0]  write_regW;
   logic [31:0] dataReadW, alu_outW;

   int n_chk = 0;
   int n_err = 0;

   logic        m_rw, m_m2r;
   logic [4:0]  m_rd;
   logic [31:0] m_alu, m_data;

   mem_access_stage #(.TIMEOUT(TMO), .XLEN(32)) dut (
      .clock(clock), .reset(reset),
      .memToRegM(memToRegM), .regWriteM(regWriteM), .memReadM(memReadM),
      .memWriteM(memWriteM), .branchM(branchM), .alu_zeroM(alu_zeroM),
      .func3M(func3M), .write_regM(write_regM), .alu_outM(alu_outM),
      .write_dataM(write_dataM), .PC_M(PC_M),
      .pcSrcM(pcSrcM), .branch_targetM(branch_targetM), .stallM(stallM),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
      .dmem_rdata(dmem_rdata),
      .memToRegW(memToRegW), .regWriteW(regWriteW), .write_regW(write_regW),
      .dataReadW(dataReadW), .alu_outW(alu_outW),
      .misalign_err(misalign_err), .bus_err(bus_err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic chk_w(input string pfx);
      chk({pfx, ".regWriteW"}, regWriteW, m_rw);
      chk({pfx, ".memToRegW"}, memToRegW, m_m2r);
      chk({pfx, ".write_regW"}, write_regW, m_rd);
      chk({pfx, ".alu_outW"}, alu_outW, m_alu);
      chk({pfx, ".dataReadW"}, dataReadW, m_data);
   endtask

   // One EX/MEM instruction; d = cycles before the slave raises ready.
   task automatic run_op(input logic rd_, input logic wr_, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdat,
                         input logic [31:0] rdat, input int d,
                         input logic rw, input logic m2r, input logic [4:0] rd);
      int unsigned sz, ofs, last;
      logic memop, mis, req, tmo, br, z;
      logic [31:0] pc, e_be, e_wd, bval, hval, lval;

      sz    = 1 << f3[1:0];
      ofs   = addr % 4;
      memop = rd_ | wr_;
      mis   = memop && (f3[1:0] == 2'b11 || (addr % sz) != 0);
      req   = memop && !mis;
      last  = req ? ((d < TMO) ? d : TMO) : 0;
      tmo   = req && (d > TMO);

      e_be = 32'hF;
      e_wd = wdat;
      if (wr_) begin
         if (sz == 1) begin
            e_be = 32'h1 << ofs;
            e_wd = (wdat & 32'hFF) * 32'h01010101;
         end else if (sz == 2) begin
            e_be = 32'h3 << ofs;
            e_wd = (wdat & 32'hFFFF) * 32'h00010001;
         end
      end
      bval = (rdat >> (8 * ofs)) & 32'hFF;
      hval = (rdat >> (8 * ofs)) & 32'hFFFF;
      case (f3)
         3'b000:  lval = (bval >= 128) ? bval + 32'hFFFFFF00 : bval;
         3'b001:  lval = (hval >= 32768) ? hval + 32'hFFFF0000 : hval;
         3'b100:  lval = bval;
         3'b101:  lval = hval;
         default: lval = rdat;
      endcase

      br = 1'($urandom_range(0, 1));
      z  = 1'($urandom_range(0, 1));
      pc = $urandom;
      memReadM = rd_; memWriteM = wr_; func3M = f3; alu_outM = addr;
      write_dataM = wdat; dmem_rdata = rdat; regWriteM = rw; memToRegM = m2r;
      write_regM = rd; branchM = br; alu_zeroM = z; PC_M = pc;

      for (int c = 0; c <= int'(last); c++) begin
         dmem_ready = (c >= d);
         @(negedge clock);
         chk("dmem_req", dmem_req, req);
         chk("stallM", stallM, c < int'(last));
         chk("pcSrcM", pcSrcM, br & z);
         chk("branch_target", branch_targetM, pc);
         if (req) begin
            chk("dmem_addr", dmem_addr, addr & 32'hFFFFFFFC);
            chk("dmem_we", dmem_we, wr_);
            chk("dmem_be", dmem_be, e_be);
            if (wr_) chk("dmem_wdata", dmem_wdata, e_wd);
         end
         @(posedge clock);
         #1;
         if (c < int'(last) || mis || tmo) begin
            m_rw  = 1'b0;
            m_m2r = 1'b0;
         end else begin
            m_rw  = rw;
            m_m2r = m2r;
            m_rd  = rd;
            m_alu = addr;
            if (rd_) m_data = lval;
         end
         chk_w("wb");
         chk("misalign_err", misalign_err, (c == int'(last)) && mis);
         chk("bus_err", bus_err, (c == int'(last)) && tmo);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, limit 200000 reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0] ld_codes [6];
      int unsigned kind, dly;
      ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};

      reset = 1'b0;
      {memToRegM, regWriteM, memReadM, memWriteM, branchM, alu_zeroM} = '0;
      func3M = '0; write_regM = '0; alu_outM = '0; write_dataM = '0; PC_M = '0;
      dmem_ready = 1'b0; dmem_rdata = '0;
      m_rw = 0; m_m2r = 0; m_rd = 0; m_alu = 0; m_data = 0;
      @(posedge clock);
      @(posedge clock);
      #1;
      chk("rst.dmem_req", dmem_req, 0);
      chk("rst.misalign_err", misalign_err, 0);
      chk("rst.bus_err", bus_err, 0);
      chk_w("rst");
      reset = 1'b1;

      // Directed cases
      run_op(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 1, 1, 5);
      chk("lw.dataReadW", dataReadW, 32'hDEADBEEF);
      run_op(1, 0, 3'b000, 32'h103, 0, 32'h80123456, 0, 1, 1, 7);
      chk("lb.dataReadW", dataReadW, 32'hFFFFFF80);
      run_op(1, 0, 3'b100, 32'h103, 0, 32'h80123456, 0, 1, 1, 7);
      chk("lbu.dataReadW", dataReadW, 32'h00000080);
      run_op(0, 1, 3'b001, 32'h102, 32'h0000ABCD, 0, 0, 0, 0, 0);
      run_op(1, 0, 3'b010, 32'h200, 0, 32'h12345678, 3, 1, 1, 9);
      run_op(1, 0, 3'b010, 32'h102, 0, 32'h55555555, 0, 1, 1, 3);
      run_op(1, 0, 3'b010, 32'h300, 0, 32'hCAFEF00D, 99, 1, 1, 4);
      run_op(1, 0, 3'b010, 32'h304, 0, 32'h0BADF00D, TMO, 1, 1, 6);

      // Reset while the FSM is waiting on the bus
      memReadM = 1; memWriteM = 0; func3M = 3'b010; alu_outM = 32'h400;
      regWriteM = 1; memToRegM = 1; write_regM = 11; dmem_ready = 0;
      @(posedge clock); #1;
      @(posedge clock); #2;
      reset = 1'b0;
      #1;
      m_rw = 0; m_m2r = 0; m_rd = 0; m_alu = 0; m_data = 0;
      chk("rstwait.dmem_req", dmem_req, 0);
      chk("rstwait.stallM", stallM, 0);
      chk_w("rstwait");
      @(posedge clock); #1;
      reset = 1'b1;
      run_op(1, 0, 3'b010, 32'h404, 0, 32'h13572468, 0, 1, 1, 12);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         kind = $urandom_range(0, 2);
         dly  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : 0;
         if (kind == 1)
            run_op(1, 0, ld_codes[$urandom_range(0, 5)], $urandom, $urandom, $urandom,
                   int'(dly), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom));
         else if (kind == 2)
            run_op(0, 1, 3'($urandom_range(0, 2)), $urandom, $urandom, $urandom,
                   int'(dly), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom));
         else
            run_op(0, 0, 3'($urandom), $urandom, $urandom, $urandom,
                   int'(dly), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
